// File: rtl/mem_bridge.sv
// Z80 bus responder: serves each core access from an asynchronous 8-bit SRAM,
// paces the core with a one-clock ce pulse and drops writes into the ROM window.
module mem_bridge #(
  parameter int         WAIT    = 2,
  parameter logic [7:0] ROM_TOP = 8'h3F
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic [7:0]  out,
  input  logic        we,
  output logic [7:0]  in,
  output logic        ce,
  output logic        wp_hit,
  output logic [15:0] sram_a,
  output logic [7:0]  sram_dq_o,
  input  logic [7:0]  sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  generate
    if (WAIT < 1 || WAIT > 15) begin : g_bad_wait
      $error("mem_bridge: WAIT must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] STROBE_LOAD = 4'(WAIT - 1);

  typedef enum logic [1:0] {LATCH, STROBE, DONE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       wr_q;
  logic       prot_q;
  logic       prot_now;
  logic       wr_now;

  // A write into the ROM window is turned into a read of the same cell.
  assign prot_now = we & (address[15:8] <= ROM_TOP);
  assign wr_now   = we & ~prot_now;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LATCH;
      cnt        <= '0;
      wr_q       <= 1'b0;
      prot_q     <= 1'b0;
      ce         <= 1'b0;
      wp_hit     <= 1'b0;
      in         <= 8'hFF;
      sram_a     <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      case (state)
        // Capture the core's bus cycle and open the strobe for the next WAIT clocks.
        LATCH: begin
          sram_a     <= address;
          sram_dq_o  <= out;
          wr_q       <= wr_now;
          prot_q     <= prot_now;
          cnt        <= STROBE_LOAD;
          sram_dq_oe <= wr_now;
          sram_we_n  <= ~wr_now;
          sram_oe_n  <= wr_now;
          state      <= STROBE;
        end
        // Write strobe ends here so DONE gives one clock of data hold.
        STROBE: begin
          if (cnt == 4'd0) begin
            ce        <= 1'b1;
            wp_hit    <= prot_q;
            sram_we_n <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        // Core advances on this edge; read data lands in `in` on the same edge.
        DONE: begin
          ce         <= 1'b0;
          wp_hit     <= 1'b0;
          in         <= wr_q ? sram_dq_o : sram_dq_i;
          sram_oe_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          state      <= LATCH;
        end
        default: state <= LATCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Randomized scoreboard bench for mem_bridge: the bench plays the Z80 core and
// the asynchronous SRAM, and predicts each access from a flat memory model.
module tb_mem_bridge;

  localparam int         WAIT    = 2;
  localparam logic [7:0] ROM_TOP = 8'h3F;
  localparam int         PERIOD  = WAIT + 2;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] address = '0;
  logic [7:0]  out     = '0;
  logic        we      = 1'b0;
  logic [7:0]  in;
  logic        ce;
  logic        wp_hit;
  logic [15:0] sram_a;
  logic [7:0]  sram_dq_o;
  logic [7:0]  sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;

  mem_bridge #(.WAIT(WAIT), .ROM_TOP(ROM_TOP)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .address    (address),
    .out        (out),
    .we         (we),
    .in         (in),
    .ce         (ce),
    .wp_hit     (wp_hit),
    .sram_a     (sram_a),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  always #5 clock = ~clock;

  // Physical SRAM: combinational read, write committed on the rising we_n edge.
  logic [7:0] sram    [0:65535];
  logic [7:0] ref_mem [0:65535];

  assign sram_dq_i = sram[sram_a];

  always @(posedge sram_we_n) begin
    if (reset_n === 1'b1) sram[sram_a] = sram_dq_o;
  end

  typedef struct packed {
    logic [15:0] a;
    logic        w;
    logic        wp;
    logic [7:0]  d;
    logic [7:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit in_rom(input logic [15:0] a);
    return int'(a) < (int'(ROM_TOP) + 1) * 256;
  endfunction

  // Issue one core bus cycle and record what the specification says it yields.
  task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
    exp_t e;
    e.a  = a;
    e.d  = d;
    e.wp = w && in_rom(a);
    e.w  = w && !e.wp;
    if (e.w) ref_mem[a] = d;
    e.rd = ref_mem[a];
    sb.push_back(e);
    address = a;
    we      = w;
    out     = d;
  endtask

  // Let the access run; garble the bus mid-access, then return in the next LATCH.
  task automatic finish_access(output bit ok);
    ok = 1'b0;
    @(posedge clock);
    #1;
    address = 16'($urandom);
    out     = 8'($urandom);
    we      = 1'($urandom);
    for (int i = 0; i < 4 * PERIOD + 8; i++) begin
      @(negedge clock);
      if (ce === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL ce_timeout: no ce pulse seen, expected one every %0d clocks", PERIOD);
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  int clk_no;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) clk_no <= 0;
    else          clk_no <= clk_no + 1;
  end

  // Monitor: strobe protocol every clock, scoreboard pop on every ce.
  bit   pend   = 1'b0;
  exp_t cur;
  int   last_ce = 0;
  int   run     = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      pend    = 1'b0;
      last_ce = 0;
      run     = 0;
    end else begin
      if (pend) begin
        chk("in_data", in, cur.rd);
        chk("sram_cell", sram[cur.a], cur.rd);
        pend = 1'b0;
      end
      if (sram_we_n === 1'b0) begin
        run++;
        chk("we_oe_overlap", sram_oe_n, 1);
        chk("dq_oe_during_write", sram_dq_oe, 1);
        if (sb.size() == 0) chk("strobe_without_access", 1, 0);
        else begin
          chk("write_addr", sram_a, sb[0].a);
          chk("write_data", sram_dq_o, sb[0].d);
          chk("write_allowed", sb[0].w, 1);
        end
      end else if (run != 0) begin
        chk("we_width", run, WAIT);
        run = 0;
      end
      if (sram_oe_n === 1'b0) begin
        chk("dq_oe_during_read", sram_dq_oe, 0);
        if (sb.size() == 0) chk("read_without_access", 1, 0);
        else chk("read_addr", sram_a, sb[0].a);
      end
      if (ce === 1'b1) begin
        chk("ce_period", clk_no + 1 - last_ce, PERIOD);
        last_ce = clk_no + 1;
        if (sb.size() == 0) chk("ce_without_access", 1, 0);
        else begin
          cur = sb.pop_front();
          chk("wp_hit", wp_hit, cur.wp);
          pend = 1'b1;
        end
      end else begin
        chk("wp_idle", wp_hit, 0);
      end
    end
  end

  logic [15:0] dir_a [10] = '{16'h4000, 16'h3FFF, 16'h4000, 16'h3FFF, 16'h0000,
                              16'hFFFF, 16'hFFFF, 16'h0000, 16'h3F00, 16'h4001};
  logic        dir_w [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0]  dir_d [10] = '{8'h5A, 8'hAA, 8'h00, 8'h00, 8'h77, 8'h99, 8'h00, 8'h00, 8'h12, 8'h34};

  initial begin
    bit          ok;
    bit          seen;
    logic [7:0]  v;
    logic [7:0]  hi;
    logic [15:0] a;
    exp_t        e;

    ok = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      v          = 8'($urandom);
      sram[i]    = v;
      ref_mem[i] = v;
    end
    sram[16'h0000] = 8'h3E; ref_mem[16'h0000] = 8'h3E;
    sram[16'h3FFF] = 8'hC3; ref_mem[16'h3FFF] = 8'hC3;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ce", ce, 0);
    chk("rst_wp_hit", wp_hit, 0);
    chk("rst_in", in, 8'hFF);
    chk("rst_sram_a", sram_a, 16'h0000);
    chk("rst_sram_dq_o", sram_dq_o, 8'h00);
    chk("rst_sram_dq_oe", sram_dq_oe, 0);
    chk("rst_sram_we_n", sram_we_n, 1);
    chk("rst_sram_oe_n", sram_oe_n, 1);

    drive(16'h0000, 1'b0, 8'h00);
    @(posedge clock);
    #1 reset_n = 1'b1;
    finish_access(ok);

    for (int i = 0; i < 10 && ok; i++) begin
      drive(dir_a[i], dir_w[i], dir_d[i]);
      finish_access(ok);
    end

    hi = ROM_TOP + 8'd1;
    for (int i = 0; i < 80 && ok; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 16'($urandom);
        1:       a = {ROM_TOP, 8'hFF};
        2:       a = {hi, 8'h00};
        3:       a = 16'hF000 + 16'($urandom_range(0, 7));
        default: a = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hFFFF;
      endcase
      drive(a, 1'($urandom_range(0, 1)), 8'($urandom));
      finish_access(ok);
    end

    if (ok) begin
      // Interrupt a write to 8000 in its strobe; the cell must not be committed.
      e.a = 16'h8000; e.w = 1'b1; e.wp = 1'b0; e.d = 8'h6C; e.rd = 8'h6C;
      sb.push_back(e);
      address = 16'h8000;
      we      = 1'b1;
      out     = 8'h6C;
      seen    = 1'b0;
      for (int i = 0; i < 2 * PERIOD + 4; i++) begin
        @(negedge clock);
        if (sram_we_n === 1'b0) begin
          seen = 1'b1;
          break;
        end
      end
      chk("rst_test_strobe_seen", seen, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_we_n", sram_we_n, 1);
      chk("midrst_oe_n", sram_oe_n, 1);
      chk("midrst_dq_oe", sram_dq_oe, 0);
      chk("midrst_in", in, 8'hFF);
      chk("midrst_ce", ce, 0);
      chk("midrst_sram_a", sram_a, 16'h0000);
      sb.delete();
      drive(16'h4000, 1'b0, 8'h00);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      finish_access(ok);
      for (int i = 0; i < 6 && ok; i++) begin
        drive((i % 2 == 0) ? 16'h8000 : 16'($urandom), 1'(i % 2), 8'($urandom));
        finish_access(ok);
      end
    end

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
